// File: rtl/banked_register_file_v2.sv
// ARMv4T banked register file: mode-banked GPRs and SPSRs, registered bypassed reads,
// CPSR/PC ownership and a two-cycle exception-entry sequencer.
module banked_register_file_v2 #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_READ_PORTS = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR   = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [NUM_READ_PORTS-1:0]            i_rd_en,
  input  logic [4*NUM_READ_PORTS-1:0]          i_rd_addr,
  output logic [DATA_WIDTH*NUM_READ_PORTS-1:0] o_rd_data,
  input  logic                                 i_wr_en,
  input  logic [3:0]                           i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                i_wr_data,
  input  logic                                 i_pc_advance,
  input  logic                                 i_cpsr_wr_en,
  input  logic                                 i_cpsr_flags_only,
  input  logic [DATA_WIDTH-1:0]                i_cpsr_wr_data,
  input  logic                                 i_exc_return,
  input  logic                                 i_exception_req,
  input  logic [2:0]                           i_exception_type,
  input  logic [DATA_WIDTH-1:0]                i_exc_return_addr,
  output logic [DATA_WIDTH-1:0]                o_pc_out,
  output logic [DATA_WIDTH-1:0]                o_cpsr_out,
  output logic [DATA_WIDTH-1:0]                o_spsr_out,
  output logic                                 o_busy
);

  localparam logic [2:0] BANK_USR = 3'd0;
  localparam logic [2:0] BANK_FIQ = 3'd1;
  localparam logic [2:0] BANK_IRQ = 3'd2;
  localparam logic [2:0] BANK_SVC = 3'd3;
  localparam logic [2:0] BANK_ABT = 3'd4;
  localparam logic [2:0] BANK_UND = 3'd5;
  localparam int         NUM_PHYS = 30;
  localparam logic [DATA_WIDTH-1:0] CPSR_RESET = DATA_WIDTH'(32'h0000_00D3);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_EXC_SAVE   = 2'd1,
    S_EXC_VECTOR = 2'd2
  } state_t;

  function automatic logic [2:0] f_mode_bank(input logic [4:0] mode);
    case (mode)
      5'b10001: return BANK_FIQ;
      5'b10010: return BANK_IRQ;
      5'b10011: return BANK_SVC;
      5'b10111: return BANK_ABT;
      5'b11011: return BANK_UND;
      default:  return BANK_USR;
    endcase
  endfunction

  function automatic logic [4:0] f_bank_mode(input logic [2:0] bank);
    case (bank)
      BANK_FIQ: return 5'b10001;
      BANK_IRQ: return 5'b10010;
      BANK_SVC: return 5'b10011;
      BANK_ABT: return 5'b10111;
      BANK_UND: return 5'b11011;
      default:  return 5'b10000;
    endcase
  endfunction

  // Physical layout: 0-12 common R0-R12, 13-17 FIQ R8-R12, 18+2*bank+{0,1} banked R13/R14.
  function automatic logic [4:0] f_phys_idx(input logic [2:0] bank, input logic [3:0] addr);
    logic [4:0] idx;
    if (addr < 4'd8) begin
      idx = {1'b0, addr};
    end else if (addr < 4'd13) begin
      idx = (bank == BANK_FIQ) ? ({1'b0, addr} + 5'd5) : {1'b0, addr};
    end else begin
      idx = 5'd18 + {1'b0, bank, 1'b0} + {4'b0000, (addr == 4'd14)};
    end
    return idx;
  endfunction

  function automatic logic f_exc_valid(input logic [2:0] etype);
    return (etype != 3'd0) && (etype != 3'd5);
  endfunction

  function automatic logic [2:0] f_exc_bank(input logic [2:0] etype);
    case (etype)
      3'd1:    return BANK_UND;
      3'd2:    return BANK_SVC;
      3'd3:    return BANK_ABT;
      3'd4:    return BANK_ABT;
      3'd6:    return BANK_IRQ;
      3'd7:    return BANK_FIQ;
      default: return BANK_USR;
    endcase
  endfunction

  state_t                          r_state;
  state_t                          w_state_next;
  logic                            w_exc_start;
  logic [2:0]                      r_exc_type;
  logic [DATA_WIDTH-1:0]           r_regs [NUM_PHYS];
  logic [DATA_WIDTH-1:0]           r_spsr [5];
  logic [DATA_WIDTH-1:0]           r_cpsr;
  logic [DATA_WIDTH-1:0]           r_pc;
  logic [DATA_WIDTH*NUM_READ_PORTS-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0]           w_spsr_cur;

  logic [2:0]            w_cur_bank;
  logic [2:0]            w_tgt_bank;
  logic                  w_gate;
  logic                  w_wr_gpr;
  logic                  w_wr_pc;
  logic [4:0]            w_wr_idx;
  logic [DATA_WIDTH-1:0] w_pc_read;

  assign w_cur_bank = f_mode_bank(r_cpsr[4:0]);
  assign w_tgt_bank = f_exc_bank(r_exc_type);
  // Strobes are dropped while busy and in the cycle an exception is accepted.
  assign w_gate     = (r_state == S_IDLE) && !w_exc_start;
  assign w_wr_gpr   = w_gate && i_wr_en && (i_wr_addr != 4'd15);
  assign w_wr_pc    = w_gate && i_wr_en && (i_wr_addr == 4'd15);
  assign w_wr_idx   = f_phys_idx(w_cur_bank, i_wr_addr);
  assign w_pc_read  = r_pc + (r_cpsr[5] ? DATA_WIDTH'(32'd4) : DATA_WIDTH'(32'd8));

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Sequencer next-state logic and exception acceptance.
  always_comb begin
    w_state_next = r_state;
    w_exc_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_exception_req && f_exc_valid(i_exception_type)) begin
          w_exc_start  = 1'b1;
          w_state_next = S_EXC_SAVE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EXC_SAVE:   w_state_next = S_EXC_VECTOR;
      S_EXC_VECTOR: w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // SPSR of the current mode; USR/SYS (and unknown modes) have none, so CPSR is shown.
  always_comb begin
    w_spsr_cur = r_cpsr;
    if (w_cur_bank != BANK_USR) w_spsr_cur = r_spsr[w_cur_bank - 3'd1];
    else                        w_spsr_cur = r_cpsr;
  end

  // Latch the accepted exception type for the rest of the sequence.
  always_ff @(posedge i_clk) begin
    if (i_reset)          r_exc_type <= 3'd0;
    else if (w_exc_start) r_exc_type <= i_exception_type;
  end

  // GPR array: normal writes plus banked R14 capture on exception entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_PHYS; i++) r_regs[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_wr_gpr) r_regs[w_wr_idx] <= i_wr_data;
      if (r_state == S_EXC_SAVE) r_regs[f_phys_idx(w_tgt_bank, 4'd14)] <= i_exc_return_addr;
    end
  end

  // SPSR capture on exception entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 5; i++) r_spsr[i] <= {DATA_WIDTH{1'b0}};
    end else if (r_state == S_EXC_SAVE) begin
      r_spsr[w_tgt_bank - 3'd1] <= r_cpsr;
    end
  end

  // CPSR: vector-stage mode switch, then restore, then explicit writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpsr <= CPSR_RESET;
    end else if (r_state == S_EXC_VECTOR) begin
      r_cpsr[7]   <= 1'b1;
      r_cpsr[6]   <= (w_tgt_bank == BANK_FIQ) ? 1'b1 : r_cpsr[6];
      r_cpsr[5]   <= 1'b0;
      r_cpsr[4:0] <= f_bank_mode(w_tgt_bank);
    end else if (w_gate && i_exc_return) begin
      r_cpsr <= w_spsr_cur;
    end else if (w_gate && i_cpsr_wr_en) begin
      if (i_cpsr_flags_only || (r_cpsr[4:0] == 5'b10000)) r_cpsr[31:28] <= i_cpsr_wr_data[31:28];
      else                                                r_cpsr <= i_cpsr_wr_data;
    end
  end

  // Program counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_VECTOR;
    end else if (r_state == S_EXC_VECTOR) begin
      r_pc <= DATA_WIDTH'({r_exc_type, 2'b00});
    end else if (w_wr_pc) begin
      r_pc <= {i_wr_data[DATA_WIDTH-1:1], 1'b0};
    end else if (w_gate && i_pc_advance) begin
      r_pc <= r_pc + (r_cpsr[5] ? DATA_WIDTH'(32'd2) : DATA_WIDTH'(32'd4));
    end
  end

  // Registered read ports with same-cycle write bypass.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= {(DATA_WIDTH*NUM_READ_PORTS){1'b0}};
    end else begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (i_rd_en[p]) begin
          if (i_rd_addr[4*p +: 4] == 4'd15)
            r_rd_data[DATA_WIDTH*p +: DATA_WIDTH] <= w_pc_read;
          else if (w_wr_gpr && (i_wr_addr == i_rd_addr[4*p +: 4]))
            r_rd_data[DATA_WIDTH*p +: DATA_WIDTH] <= i_wr_data;
          else
            r_rd_data[DATA_WIDTH*p +: DATA_WIDTH] <= r_regs[f_phys_idx(w_cur_bank, i_rd_addr[4*p +: 4])];
        end
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_pc_out   = r_pc;
  assign o_cpsr_out = r_cpsr;
  assign o_spsr_out = w_spsr_cur;
  assign o_busy     = (r_state != S_IDLE);

endmodule
